// File: rtl/scarv_ccx_mmio_pkg.sv
// Shared definitions for the core-complex MMIO machine timer.
// Holds the word-index register map, the CTRL field positions, the reset
// constants and a byte-strobe merge helper used by the register writes.
package scarv_ccx_mmio_pkg;

  // Word index (addr[7:2]) of each register.
  localparam logic [5:0] IDX_MTIME_LO  = 6'd0;
  localparam logic [5:0] IDX_MTIME_HI  = 6'd1;
  localparam logic [5:0] IDX_CMP_LO    = 6'd2;
  localparam logic [5:0] IDX_CMP_HI    = 6'd3;
  localparam logic [5:0] IDX_CTRL      = 6'd4;
  localparam logic [5:0] IDX_SHADOW_HI = 6'd5;

  // CTRL layout: EN in bit 0, DIV starts at bit 8.
  localparam int CTRL_EN_POS  = 0;
  localparam int CTRL_DIV_POS = 8;

  // Reset values.
  localparam logic [63:0] MTIME_RST  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic        EN_RST     = 1'b1;
  localparam logic [31:0] WORD_RST   = 32'h0000_0000;

  // Replace the bytes of old_val selected by strb with those of new_val.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scarv_ccx_mmio_prescaler.sv
// Prescaler for the machine timer.
// Ports: clk/resetn (sync active-low), en (count enable), div (terminal
// count), clr (restart the count at 0), tick (one-cycle increment strobe).
// While enabled the count runs 0..div and tick is high on the cycle the count
// equals div, so div=0 ticks every cycle.
module scarv_ccx_mmio_prescaler #(
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [PSC_W-1:0] div,
  input  logic             clr,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt_r;

  // The tick is derived from the current count so the counter sees it in the
  // same cycle; clr only affects the next count value.
  assign tick = en && (psc_cnt_r == div);

  // Prescaler count: cleared by reset or clr, wraps at div, frozen when disabled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      psc_cnt_r <= {PSC_W{1'b0}};
    end else if (clr) begin
      psc_cnt_r <= {PSC_W{1'b0}};
    end else if (tick) begin
      psc_cnt_r <= {PSC_W{1'b0}};
    end else if (en) begin
      psc_cnt_r <= psc_cnt_r + {{(PSC_W-1){1'b0}}, 1'b1};
    end else begin
      psc_cnt_r <= psc_cnt_r;
    end
  end

endmodule

// File: rtl/scarv_ccx_mmio_timer.sv
// Memory-mapped 64-bit mtime/mtimecmp machine timer on the core-complex MMIO
// responder port. Never stalls (gnt tied high); each accepted word access gets
// rdata/error registered one cycle later and held until the next accept.
// Ports: g_clk, g_resetn (sync active-low); mmio_req/gnt/wen/strb/addr/wdata
// request side; mmio_rdata/mmio_error response; timer_irq = registered
// (mtime >= mtimecmp).
module scarv_ccx_mmio_timer
  import scarv_ccx_mmio_pkg::*;
#(
  parameter int          AW        = 32,
  parameter int          DW        = 32,
  parameter logic [31:0] MMIO_BASE = 32'h0002_0000,
  parameter int          PSC_W     = 8
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          mmio_req,
  output logic          mmio_gnt,
  input  logic          mmio_wen,
  input  logic [3:0]    mmio_strb,
  input  logic [AW-1:0] mmio_addr,
  input  logic [DW-1:0] mmio_wdata,
  output logic [DW-1:0] mmio_rdata,
  output logic          mmio_error,
  output logic          timer_irq
);

  logic [63:0]      mtime_r;
  logic [63:0]      cmp_r;
  logic             en_r;
  logic [PSC_W-1:0] div_r;
  logic [31:0]      shadow_r;
  logic [31:0]      rdata_r;
  logic             error_r;
  logic             irq_r;

  logic             tick_s;
  logic             wr_s;
  logic             ctrl_wr_s;
  logic [5:0]       idx_s;
  logic [63:0]      mtime_inc_s;
  logic [63:0]      mtime_nxt_s;
  logic [63:0]      cmp_nxt_s;
  logic [31:0]      ctrl_rd_s;
  logic [31:0]      ctrl_new_s;
  logic [31:0]      rd_val_s;
  logic             err_s;
  logic             unused_s;

  // Router already range-checks the address; only the word index matters here.
  assign unused_s   = ^{mmio_addr[AW-1:8], mmio_addr[1:0], MMIO_BASE, ctrl_new_s};
  assign mmio_gnt   = 1'b1;
  assign mmio_rdata = rdata_r;
  assign mmio_error = error_r;
  assign timer_irq  = irq_r;

  scarv_ccx_mmio_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk    (g_clk),
    .resetn (g_resetn),
    .en     (en_r),
    .div    (div_r),
    .clr    (ctrl_wr_s),
    .tick   (tick_s)
  );

  // CTRL read view: EN and DIV fields, all other bits read as zero.
  always_comb begin
    ctrl_rd_s                          = 32'h0000_0000;
    ctrl_rd_s[CTRL_EN_POS]             = en_r;
    ctrl_rd_s[CTRL_DIV_POS +: PSC_W]   = div_r;
  end

  // Address decode, read mux and next-state of the strobed 64-bit registers.
  // Written MTIME bytes override the incremented value, unwritten bytes keep it.
  always_comb begin
    idx_s       = mmio_addr[7:2];
    wr_s        = mmio_req && mmio_wen;
    mtime_inc_s = tick_s ? (mtime_r + 64'd1) : mtime_r;
    mtime_nxt_s = mtime_inc_s;
    cmp_nxt_s   = cmp_r;
    ctrl_new_s  = strb_merge(ctrl_rd_s, mmio_wdata, mmio_strb);
    ctrl_wr_s   = 1'b0;
    rd_val_s    = 32'h0000_0000;
    err_s       = 1'b0;
    case (idx_s)
      IDX_MTIME_LO: begin
        rd_val_s = mtime_r[31:0];
        if (wr_s) begin
          mtime_nxt_s[31:0] = strb_merge(mtime_inc_s[31:0], mmio_wdata, mmio_strb);
        end else begin
          mtime_nxt_s = mtime_inc_s;
        end
      end
      IDX_MTIME_HI: begin
        rd_val_s = mtime_r[63:32];
        if (wr_s) begin
          mtime_nxt_s[63:32] = strb_merge(mtime_inc_s[63:32], mmio_wdata, mmio_strb);
        end else begin
          mtime_nxt_s = mtime_inc_s;
        end
      end
      IDX_CMP_LO: begin
        rd_val_s = cmp_r[31:0];
        if (wr_s) begin
          cmp_nxt_s[31:0] = strb_merge(cmp_r[31:0], mmio_wdata, mmio_strb);
        end else begin
          cmp_nxt_s = cmp_r;
        end
      end
      IDX_CMP_HI: begin
        rd_val_s = cmp_r[63:32];
        if (wr_s) begin
          cmp_nxt_s[63:32] = strb_merge(cmp_r[63:32], mmio_wdata, mmio_strb);
        end else begin
          cmp_nxt_s = cmp_r;
        end
      end
      IDX_CTRL: begin
        rd_val_s  = ctrl_rd_s;
        // An all-zero strobe is a no-op, so it must not restart the prescaler.
        ctrl_wr_s = wr_s && (mmio_strb != 4'b0000);
      end
      IDX_SHADOW_HI: begin
        rd_val_s = shadow_r;
        err_s    = mmio_wen;
      end
      default: begin
        rd_val_s = 32'h0000_0000;
        err_s    = 1'b1;
      end
    endcase
  end

  // Timer state, IRQ compare flop and registered bus response.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      mtime_r  <= MTIME_RST;
      cmp_r    <= CMP_RST;
      en_r     <= EN_RST;
      div_r    <= {PSC_W{1'b0}};
      shadow_r <= WORD_RST;
      rdata_r  <= WORD_RST;
      error_r  <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      mtime_r <= mtime_nxt_s;
      cmp_r   <= cmp_nxt_s;
      irq_r   <= (mtime_r >= cmp_r);
      if (ctrl_wr_s) begin
        en_r  <= ctrl_new_s[CTRL_EN_POS];
        div_r <= ctrl_new_s[CTRL_DIV_POS +: PSC_W];
      end
      if (mmio_req) begin
        // Writes return zero data; reads return the pre-update register value.
        rdata_r <= mmio_wen ? 32'h0000_0000 : rd_val_s;
        error_r <= err_s;
        if (!mmio_wen && (idx_s == IDX_MTIME_LO)) begin
          shadow_r <= mtime_r[63:32];
        end
      end
    end
  end

endmodule

// File: tb/tb_scarv_ccx_mmio_timer.sv
// Scoreboard bench for scarv_ccx_mmio_timer: the driver computes the expected
// outcome of every cycle from a behavioural timer model and queues it; the
// monitor samples the DUT after each rising edge and compares.
module tb_scarv_ccx_mmio_timer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  strb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        gnt;
  logic [31:0] rdata;
  logic        error;
  logic        irq;

  always #5 clk = ~clk;

  scarv_ccx_mmio_timer dut (
    .g_clk      (clk),
    .g_resetn   (resetn),
    .mmio_req   (req),
    .mmio_gnt   (gnt),
    .mmio_wen   (wen),
    .mmio_strb  (strb),
    .mmio_addr  (addr),
    .mmio_wdata (wdata),
    .mmio_rdata (rdata),
    .mmio_error (error),
    .timer_irq  (irq)
  );

  typedef struct {
    logic        irq;
    logic        has_rsp;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural model state.
  longint unsigned m_mtime;
  longint unsigned m_cmp;
  bit              m_en;
  int unsigned     m_div;
  int unsigned     m_phase;   // cycles elapsed in the current prescaler period
  logic [31:0]     m_shadow;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en     = 1'b1;
    m_div    = 0;
    m_phase  = 0;
    m_shadow = 32'h0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, predict, advance the model.
  task automatic step(input bit rn, input bit r, input bit w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    exp_t            e;
    bit              tick;
    longint unsigned nt;
    logic [63:0]     v;
    logic [31:0]     rv;
    logic [31:0]     cv;
    int              idx;
    @(negedge clk);
    resetn = rn; req = r; wen = w; strb = s; addr = a; wdata = d;
    e.rdata = 32'h0; e.err = 1'b0; e.has_rsp = 1'b0; e.irq = 1'b0;
    if (!rn) begin
      e.has_rsp = 1'b1;
      model_reset();
    end else begin
      e.irq   = (m_mtime >= m_cmp);
      tick    = m_en && (m_phase == m_div);
      nt      = m_mtime + (tick ? 64'd1 : 64'd0);
      if (m_en) m_phase = tick ? 0 : m_phase + 1;
      idx     = int'(a[7:2]);
      rv      = 32'h0;
      e.has_rsp = r;
      if (r) begin
        case (idx)
          0: begin
            rv = m_mtime[31:0];
            if (!w) m_shadow = m_mtime[63:32];
            else begin v = nt; v[31:0] = bmerge(v[31:0], d, s); nt = v; end
          end
          1: begin
            rv = m_mtime[63:32];
            if (w) begin v = nt; v[63:32] = bmerge(v[63:32], d, s); nt = v; end
          end
          2: begin
            rv = m_cmp[31:0];
            if (w) begin v = m_cmp; v[31:0] = bmerge(v[31:0], d, s); m_cmp = v; end
          end
          3: begin
            rv = m_cmp[63:32];
            if (w) begin v = m_cmp; v[63:32] = bmerge(v[63:32], d, s); m_cmp = v; end
          end
          4: begin
            rv = {16'h0, m_div[7:0], 7'h0, m_en};
            if (w && s != 4'h0) begin
              cv      = bmerge(rv, d, s);
              m_en    = cv[0];
              m_div   = int'(cv[15:8]);
              m_phase = 0;
            end
          end
          5: begin rv = m_shadow; e.err = w; end
          default: e.err = 1'b1;
        endcase
        e.rdata = w ? 32'h0 : rv;
      end
      m_mtime = nt;
    end
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    step(1'b1, 1'b1, 1'b1, s, a, d);
  endtask
  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask
  task automatic rst();
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Monitor: compare outputs after every rising edge that follows a driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", {31'h0, gnt}, 32'h1);
        chk("irq", {31'h0, irq}, {31'h0, e.irq});
        if (e.has_rsp) begin
          chk("rdata", rdata, e.rdata);
          chk("error", {31'h0, error}, {31'h0, e.err});
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rdv;
    int          sel;
    model_reset();
    // Reset state.
    rst(); rst();
    rd(32'h00); rd(32'h08); rd(32'h10); rd(32'h0C); idle(1);
    // IRQ timing with DIV=0.
    wr(32'h10, 32'h1); wr(32'h0C, 32'h0); wr(32'h08, 32'd20); wr(32'h00, 32'h0);
    idle(25);
    // 64-bit wrap and carry.
    wr(32'h00, 32'hFFFF_FFFF); wr(32'h04, 32'hFFFF_FFFF);
    rd(32'h00); rd(32'h04); idle(2); rd(32'h00); rd(32'h04);
    // DIV=3 prescaling, then freeze.
    wr(32'h10, 32'h0000_0301); idle(13); rd(32'h00); rd(32'h10);
    wr(32'h10, 32'h0); idle(6); rd(32'h00); rd(32'h00);
    // Error responses and byte strobes.
    wr(32'h14, 32'h1234_5678); rd(32'h40); wr(32'h40, 32'h1); rd(32'h14);
    wr(32'h08, 32'hAABB_CCDD, 4'b0010); rd(32'h08);
    wr(32'h08, 32'h5555_5555, 4'b0000); rd(32'h08);
    // Shadow across the low-word wrap, then reset mid-sequence.
    wr(32'h10, 32'h1); wr(32'h04, 32'h5); wr(32'h00, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin rd(32'h00); rd(32'h14); end
    rd(32'h00); rst(); idle(1);
    rd(32'h00); rd(32'h08); rd(32'h0C); rd(32'h10); rd(32'h14);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 9));
      ra  = (sel <= 5) ? 32'(sel * 4) : ((sel == 6) ? 32'h40 : ($urandom & 32'hFF));
      rdv = $urandom;
      if (ra[7:2] == 6'd4) rdv = {16'h0, 6'h0, 2'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 7) != 0)};
      if (ra[7:2] == 6'd2 || ra[7:2] == 6'd3) rdv = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 64)) : rdv;
      if (ra[7:2] == 6'd1) rdv = ($urandom_range(0, 3) != 0) ? 32'h0 : rdv;
      if ($urandom_range(0, 299) == 0) rst();
      else if ($urandom_range(0, 3) == 0) idle(1);
      else step(1'b1, 1'b1, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF, ra, rdv);
    end
    idle(2);
    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
